// File: rtl/bus_arbiter4.sv
// bus_arbiter4: four-requester round-robin bus arbiter with a bounded hold time.
// A requester keeps the bus while its req stays high. Once it has held the bus
// for MAX_HOLD cycles it is forced off if anyone else is waiting. A sole
// requester is never forced off.
// Optional feature macro: BUS_TURNAROUND_EN. When it is defined, every release
// passes through one TURN cycle with all grants low, so two tristate drivers
// never overlap on the shared bus. When it is undefined, ownership passes
// directly from one requester to the next.
// gnt, owner and busy are all taken straight from flops.
module bus_arbiter4 #(
  parameter int MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] owner,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    TURN  = 2'd2
  } state_t;

  localparam logic [7:0] MAX_HOLD_C = 8'(MAX_HOLD);

  state_t     state_r, state_s;
  logic [3:0] gnt_r, gnt_s;
  logic [1:0] owner_r, owner_s;
  logic       busy_r, busy_s;
  logic [1:0] ptr_r, ptr_s;
  logic [7:0] hold_r, hold_s;

  logic       pick_vld_s;
  logic [1:0] pick_idx_s;
  logic       others_s;
  logic       release_s;

  // Round-robin search: return the first set request at or above p, modulo 4.
  // Bit 2 of the result flags whether any request was found.
  function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int k = 3; k >= 0; k--) begin
      idx = p + k[1:0];
      if (r[idx]) begin
        res = {1'b1, idx};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  // Arbitration inputs: the round-robin pick, whether anyone besides the owner
  // is waiting, and whether the current owner must give up the bus.
  always_comb begin
    {pick_vld_s, pick_idx_s} = rr_pick(req, ptr_r);
    others_s  = |(req & ~gnt_r);
    release_s = ~req[owner_r] | ((hold_r == MAX_HOLD_C) & others_s);
  end

  // Next-state and next-output logic. The outputs are computed one cycle ahead
  // and then registered.
  always_comb begin
    state_s = state_r;
    gnt_s   = gnt_r;
    owner_s = owner_r;
    busy_s  = busy_r;
    ptr_s   = ptr_r;
    hold_s  = hold_r;
    case (state_r)
      IDLE, TURN: begin
        if (pick_vld_s) begin
          state_s = GRANT;
          gnt_s   = 4'b0001 << pick_idx_s;
          owner_s = pick_idx_s;
          busy_s  = 1'b1;
          ptr_s   = pick_idx_s + 2'd1;
          hold_s  = 8'd1;
        end else begin
          state_s = IDLE;
          gnt_s   = 4'b0000;
          busy_s  = 1'b0;
          hold_s  = 8'd0;
        end
      end
      GRANT: begin
        if (release_s) begin
`ifdef BUS_TURNAROUND_EN
          state_s = TURN;
          gnt_s   = 4'b0000;
          busy_s  = 1'b0;
          hold_s  = 8'd0;
`else
          // The old owner sits at the far end of the search, because ptr was
          // set to owner+1 when it was granted, so it has the lowest priority.
          if (pick_vld_s) begin
            state_s = GRANT;
            gnt_s   = 4'b0001 << pick_idx_s;
            owner_s = pick_idx_s;
            busy_s  = 1'b1;
            ptr_s   = pick_idx_s + 2'd1;
            hold_s  = 8'd1;
          end else begin
            state_s = IDLE;
            gnt_s   = 4'b0000;
            busy_s  = 1'b0;
            hold_s  = 8'd0;
          end
`endif
        end else begin
          if (hold_r == MAX_HOLD_C) begin
            hold_s = hold_r;
          end else begin
            hold_s = hold_r + 8'd1;
          end
        end
      end
      default: begin
        state_s = IDLE;
        gnt_s   = 4'b0000;
        owner_s = 2'd0;
        busy_s  = 1'b0;
        hold_s  = 8'd0;
      end
    endcase
  end

  // State and output registers, with a synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= IDLE;
      gnt_r   <= 4'b0000;
      owner_r <= 2'd0;
      busy_r  <= 1'b0;
      ptr_r   <= 2'd0;
      hold_r  <= 8'd0;
    end else begin
      state_r <= state_s;
      gnt_r   <= gnt_s;
      owner_r <= owner_s;
      busy_r  <= busy_s;
      ptr_r   <= ptr_s;
      hold_r  <= hold_s;
    end
  end

  assign gnt   = gnt_r;
  assign owner = owner_r;
  assign busy  = busy_r;

endmodule

// File: tb/tb_bus_arbiter4.sv
// tb_bus_arbiter4: directed scoreboard bench for two arbiter instances.
// dut2 is built with MAX_HOLD=2 and dut8 with the default MAX_HOLD=8.
// Each step queues the grant expected after the coming edge. A negedge monitor
// pops each queued entry and compares it against the DUT outputs. The monitor
// also checks the one-hot and busy invariants on every cycle.
module tb_bus_arbiter4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req2, req8;
  logic [3:0] gnt2, gnt8;
  logic [1:0] owner2, owner8;
  logic       busy2, busy8;

  typedef struct {
    int         due;
    logic [3:0] gnt;
    logic       was_rst;
  } exp_t;

  exp_t q2[$];
  exp_t q8[$];
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;

  bus_arbiter4 #(.MAX_HOLD(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .req(req2), .gnt(gnt2), .owner(owner2), .busy(busy2)
  );

  bus_arbiter4 dut8 (
    .clk(clk), .rst_n(rst_n), .req(req8), .gnt(gnt8), .owner(owner8), .busy(busy8)
  );

  always #5 clk = ~clk;

  // Cycle counter used to align queued expectations with the edges they follow.
  always @(posedge clk) cyc <= cyc + 1;

  // Compare one scoreboard entry with the sampled outputs of one DUT.
  task automatic check_entry(input string nm, input exp_t e, input logic [3:0] g,
                             input logic b, input logic [1:0] o);
    logic [1:0] exp_owner;
    logic       chk_owner;
    exp_owner = 2'd0;
    chk_owner = e.was_rst;
    for (int i = 0; i < 4; i++) begin
      if (e.gnt[i]) begin
        exp_owner = 2'(i);
        chk_owner = 1'b1;
      end
    end
    total++;
    if (g !== e.gnt || b !== (|e.gnt) || (chk_owner && o !== exp_owner)) begin
      bad++;
      $display("FAIL %s cyc=%0d: got gnt=%b busy=%b owner=%0d, want gnt=%b busy=%b owner=%0d",
               nm, cyc, g, b, o, e.gnt, |e.gnt, exp_owner);
    end
  endtask

  // Monitor: invariants on every cycle, plus the scoreboard entries that are due.
  always @(negedge clk) begin
    if (cyc >= 1) begin
      total++;
      if ($countones(gnt2) > 1 || busy2 !== (|gnt2)) begin
        bad++;
        $display("FAIL inv2 cyc=%0d: gnt=%b busy=%b", cyc, gnt2, busy2);
      end
      total++;
      if ($countones(gnt8) > 1 || busy8 !== (|gnt8)) begin
        bad++;
        $display("FAIL inv8 cyc=%0d: gnt=%b busy=%b", cyc, gnt8, busy8);
      end
    end
    while (q2.size() > 0 && q2[0].due <= cyc) begin
      if (q2[0].due < cyc) begin
        total++; bad++;
        $display("FAIL stale2 cyc=%0d: entry due %0d, want none", cyc, q2[0].due);
      end else begin
        check_entry("dut2", q2[0], gnt2, busy2, owner2);
      end
      void'(q2.pop_front());
    end
    while (q8.size() > 0 && q8[0].due <= cyc) begin
      if (q8[0].due < cyc) begin
        total++; bad++;
        $display("FAIL stale8 cyc=%0d: entry due %0d, want none", cyc, q8[0].due);
      end else begin
        check_entry("dut8", q8[0], gnt8, busy8, owner8);
      end
      void'(q8.pop_front());
    end
  end

  // Drive one cycle of inputs and queue the expected outputs after the next edge.
  task automatic step(input logic rst, input logic [3:0] r2, input logic [3:0] e2,
                      input logic [3:0] r8, input logic [3:0] e8);
    exp_t x;
    rst_n = rst;
    req2  = r2;
    req8  = r8;
    x.due = cyc + 1;
    x.was_rst = ~rst;
    x.gnt = e2;
    q2.push_back(x);
    x.gnt = e8;
    q8.push_back(x);
    @(posedge clk);
    #1;
  endtask

  logic [3:0] rr_exp [9];

  initial begin
    rst_n = 1'b0;
    req2  = 4'b0000;
    req8  = 4'b0000;
`ifdef BUS_TURNAROUND_EN
    rr_exp = '{4'b0001, 4'b0001, 4'b0000, 4'b0010, 4'b0010,
               4'b0000, 4'b0100, 4'b0100, 4'b0000};
`else
    rr_exp = '{4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0100,
               4'b0100, 4'b1000, 4'b1000, 4'b0001};
`endif
    // Reset state.
    step(1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    step(1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    // Reset in the middle of a grant, while gnt=0100.
    step(1'b1, 4'b0100, 4'b0100, 4'b0000, 4'b0000);
    step(1'b1, 4'b0100, 4'b0100, 4'b0000, 4'b0000);
    step(1'b0, 4'b0100, 4'b0000, 4'b0000, 4'b0000);
    // Round-robin with all four requesting; the first arbitration uses ptr=0.
    for (int i = 0; i < 9; i++) step(1'b1, 4'b1111, rr_exp[i], 4'b0000, 4'b0000);
    // Early release, then round-robin resumes from ptr=2.
    step(1'b0, 4'b1111, 4'b0000, 4'b0000, 4'b0000);
    step(1'b1, 4'b0010, 4'b0010, 4'b0000, 4'b0000);
    step(1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    step(1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    step(1'b1, 4'b0011, 4'b0001, 4'b0000, 4'b0000);
    step(1'b1, 4'b0011, 4'b0001, 4'b0000, 4'b0000);
    // Hold limit reached with another requester waiting: forced release.
`ifdef BUS_TURNAROUND_EN
    step(1'b1, 4'b0011, 4'b0000, 4'b0000, 4'b0000);
`endif
    step(1'b1, 4'b0011, 4'b0010, 4'b0000, 4'b0000);
    // Owner drops its request while requester 0 waits.
`ifdef BUS_TURNAROUND_EN
    step(1'b1, 4'b0001, 4'b0000, 4'b0000, 4'b0000);
`endif
    step(1'b1, 4'b0001, 4'b0001, 4'b0000, 4'b0000);
    step(1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    // Sole requester on the MAX_HOLD=8 instance is never forced off.
    for (int i = 0; i < 20; i++) step(1'b1, 4'b0000, 4'b0000, 4'b0100, 4'b0100);
    step(1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    step(1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    @(negedge clk);
    #1;
    total++;
    if (q2.size() != 0 || q8.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d/%0d entries left, want 0/0", q2.size(), q8.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
